// File: rtl/faultsim_pkg.sv
// Shared types and sizing helpers for the exhaustive pattern controller.
package faultsim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  localparam int NIN_DEF = 2;
  localparam int NPAT    = 1 << NIN_DEF;
  localparam int CNTW    = NIN_DEF + 1;

  // Settle counter needs to hold 0..SETTLE-1, but never drops below one bit.
  function automatic int settle_w(input int settle);
    int w;
    w = $clog2(settle);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/exh_pattern_ctrl_pat_cnt.sv
// Pattern index and per-pattern settle counter for the exhaustive sequencer.
module pat_cnt
  import faultsim_pkg::*;
#(
  parameter int NIN    = 2,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           adv,
  input  logic           tick,
  output logic [NIN-1:0] idx,
  output logic           settled,
  output logic           last
);

  localparam int SW = settle_w(SETTLE);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE - 1);

  logic [NIN-1:0] r_idx;
  logic [SW-1:0]  r_cnt;

  // Pattern index: restarts on a new run, steps once per completed capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (adv) begin
      r_idx <= r_idx + NIN'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Settle counter only advances while a pattern is being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || !tick || settled) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + SW'(1);
    end
  end

  assign idx     = r_idx;
  assign settled = tick && (r_cnt == SETTLE_MAX);
  assign last    = &r_idx;

endmodule

// File: rtl/exh_pattern_ctrl.sv
// Exhaustive pattern sequencer: drives every input pattern to a gate under test,
// captures its response after a settle time and compares against a golden table.
module exh_pattern_ctrl
  import faultsim_pkg::*;
#(
  parameter int                    NIN    = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<NIN)-1:0]   GOLDEN = 4'b0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pattout,
  output logic [NIN-1:0]        pattin,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NIN:0]          fail_cnt,
  output logic [NIN-1:0]        first_fail,
  output logic                  first_fail_vld,
  output logic [(1<<NIN)-1:0]   resp,
  output logic                  aborted
);

  localparam int NPAT_L = 1 << NIN;
  localparam int CNTW_L = NIN + 1;

  state_t              r_state, w_state_nxt;
  logic [NIN-1:0]      w_idx, w_idx_nxt;
  logic                w_settled, w_last;
  logic                w_start_acc, w_abort_act, w_capture;

  logic [NIN-1:0]      r_pattin, w_pattin_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [CNTW_L-1:0]   r_fail_cnt, w_fail_nxt;
  logic [NIN-1:0]      r_first_fail, w_ff_nxt;
  logic                r_ffv, w_ffv_nxt;
  logic [NPAT_L-1:0]   r_resp, w_resp_nxt;
  logic                r_aborted, w_aborted_nxt;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_abort_act = abort && ((r_state == ST_APPLY) || (r_state == ST_CAPTURE));
  assign w_capture   = (r_state == ST_CAPTURE) && !abort;

  pat_cnt #(
    .NIN    (NIN),
    .SETTLE (SETTLE)
  ) u_pat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_start_acc),
    .adv     (w_capture && !w_last),
    .tick    ((r_state == ST_APPLY) && !abort),
    .idx     (w_idx),
    .settled (w_settled),
    .last    (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort only matters while a pattern is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = start ? ST_APPLY : ST_IDLE;
      ST_APPLY:   w_state_nxt = abort ? ST_IDLE : (w_settled ? ST_CAPTURE : ST_APPLY);
      ST_CAPTURE: w_state_nxt = abort ? ST_IDLE : (w_last ? ST_FINISH : ST_APPLY);
      ST_FINISH:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for every registered output, derived from the next state.
  always_comb begin
    w_fail_nxt    = r_fail_cnt;
    w_resp_nxt    = r_resp;
    w_ff_nxt      = r_first_fail;
    w_ffv_nxt     = r_ffv;
    w_pass_nxt    = r_pass;
    w_aborted_nxt = r_aborted;
    if (w_start_acc) begin
      w_fail_nxt    = '0;
      w_resp_nxt    = '0;
      w_ff_nxt      = '0;
      w_ffv_nxt     = 1'b0;
      w_pass_nxt    = 1'b0;
      w_aborted_nxt = 1'b0;
    end else if (w_capture) begin
      w_resp_nxt[w_idx] = pattout;
      if (pattout != GOLDEN[w_idx]) begin
        w_fail_nxt = r_fail_cnt + CNTW_L'(1);
        w_ff_nxt   = r_ffv ? r_first_fail : w_idx;
        w_ffv_nxt  = 1'b1;
      end else begin
        w_fail_nxt = r_fail_cnt;
      end
      // Pass becomes visible in the FINISH cycle, so include this final capture.
      w_pass_nxt = w_last ? (w_fail_nxt == '0) : r_pass;
    end else if (w_abort_act) begin
      w_aborted_nxt = 1'b1;
      w_pass_nxt    = 1'b0;
    end else begin
      w_aborted_nxt = r_aborted;
    end

    case (r_state)
      ST_APPLY:   w_idx_nxt = w_idx;
      ST_CAPTURE: w_idx_nxt = w_idx + NIN'(1);
      default:    w_idx_nxt = '0;
    endcase
    w_busy_nxt   = (w_state_nxt == ST_APPLY) || (w_state_nxt == ST_CAPTURE);
    w_done_nxt   = (w_state_nxt == ST_FINISH);
    w_pattin_nxt = w_busy_nxt ? w_idx_nxt : '0;
  end

  // Output and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattin     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_cnt   <= '0;
      r_first_fail <= '0;
      r_ffv        <= 1'b0;
      r_resp       <= '0;
      r_aborted    <= 1'b0;
    end else begin
      r_pattin     <= w_pattin_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_fail_cnt   <= w_fail_nxt;
      r_first_fail <= w_ff_nxt;
      r_ffv        <= w_ffv_nxt;
      r_resp       <= w_resp_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  assign pattin         = r_pattin;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail_cnt       = r_fail_cnt;
  assign first_fail     = r_first_fail;
  assign first_fail_vld = r_ffv;
  assign resp           = r_resp;
  assign aborted        = r_aborted;

endmodule

// File: tb/tb_exh_pattern_ctrl.sv
// Scoreboard bench for exh_pattern_ctrl: default instance with a selectable faulty GUT,
// plus a SETTLE=3 instance driven by a fault-free NOR.
module tb_exh_pattern_ctrl;

  typedef struct packed {
    logic [3:0] resp;
    logic [2:0] fail_cnt;
    logic [1:0] first_fail;
    logic       ffv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start3 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       pattout, pattout3;
  logic [1:0] pattin, pattin3;
  logic       busy, done, pass, ffv, aborted;
  logic       busy3, done3, pass3, ffv3, aborted3;
  logic [2:0] fail_cnt, fail_cnt3;
  logic [1:0] first_fail, first_fail3;
  logic [3:0] resp, resp3;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // GUT model: 0 = NOR {a,b}, 1 = out stuck-at-0, 2 = out stuck-at-1, 3 = a stuck-at-0
  always_comb begin
    case (mode)
      2'd0:    pattout = ~(pattin[1] | pattin[0]);
      2'd1:    pattout = 1'b0;
      2'd2:    pattout = 1'b1;
      2'd3:    pattout = ~pattin[0];
      default: pattout = 1'b0;
    endcase
  end
  assign pattout3 = ~(pattin3[1] | pattin3[0]);

  exh_pattern_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattout(pattout),
    .pattin(pattin), .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .first_fail_vld(ffv), .resp(resp), .aborted(aborted)
  );

  exh_pattern_ctrl #(.NIN(2), .SETTLE(3), .GOLDEN(4'b0001)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .pattout(pattout3),
    .pattin(pattin3), .busy(busy3), .done(done3), .pass(pass3), .fail_cnt(fail_cnt3),
    .first_fail(first_fail3), .first_fail_vld(ffv3), .resp(resp3), .aborted(aborted3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_resp", 32'(resp), 32'(e.resp));
        check("sb_fail_cnt", 32'(fail_cnt), 32'(e.fail_cnt));
        check("sb_first_fail_vld", 32'(ffv), 32'(e.ffv));
        if (e.ffv) check("sb_first_fail", 32'(first_fail), 32'(e.first_fail));
        check("sb_pass", 32'(pass), 32'(e.pass));
        check("sb_aborted", 32'(aborted), 32'd0);
      end
    end
  end

  task automatic run(input logic [1:0] m, input exp_t e);
    bit seen;
    mode = m;
    sb_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("done_timeout", 32'(seen), 32'd1);
    repeat (3) tick();
    check("hold_resp", 32'(resp), 32'(e.resp));
    check("hold_fail_cnt", 32'(fail_cnt), 32'(e.fail_cnt));
  endtask

  initial begin
    int dc;
    #12;
    check("rst_pattin", 32'(pattin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_results", {22'd0, resp, fail_cnt, first_fail, ffv, pass}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fault-free NOR with exact cycle timing: start sampled at cycle 0.
    mode = 2'd0;
    sb_q.push_back('{resp: 4'b0001, fail_cnt: 3'd0, first_fail: 2'd0, ffv: 1'b0, pass: 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("t_busy_c%0d", k), 32'(busy), 32'(k <= 8));
      check($sformatf("t_done_c%0d", k), 32'(done), 32'(k == 9));
      check($sformatf("t_pattin_c%0d", k), 32'(pattin), (k <= 8) ? 32'((k - 1) / 2) : 32'd0);
      tick();
    end
    repeat (2) tick();

    run(2'd1, '{resp: 4'b0000, fail_cnt: 3'd1, first_fail: 2'd0, ffv: 1'b1, pass: 1'b0});
    run(2'd2, '{resp: 4'b1111, fail_cnt: 3'd3, first_fail: 2'd1, ffv: 1'b1, pass: 1'b0});
    run(2'd3, '{resp: 4'b0101, fail_cnt: 3'd1, first_fail: 2'd2, ffv: 1'b1, pass: 1'b0});

    // SETTLE=3 instance: each pattern held 4 cycles, busy 16 cycles.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("s3_busy_c%0d", k), 32'(busy3), 32'(k <= 16));
      check($sformatf("s3_pattin_c%0d", k), 32'(pattin3), (k <= 16) ? 32'((k - 1) / 4) : 32'd0);
      check($sformatf("s3_done_c%0d", k), 32'(done3), 32'(k == 17));
      tick();
    end
    check("s3_pass", 32'(pass3), 32'd1);
    check("s3_resp", 32'(resp3), 32'h1);

    // Abort during idx=2 CAPTURE (cycle 6) with a stray start at cycle 3.
    mode = 2'd2;
    dc = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("ab_capture_idx", 32'(pattin), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_aborted", 32'(aborted), 32'd1);
    check("ab_pass", 32'(pass), 32'd0);
    check("ab_resp", 32'(resp), 32'h3);
    check("ab_fail_cnt", 32'(fail_cnt), 32'd1);
    check("ab_first_fail", 32'(first_fail), 32'd1);
    check("ab_pattin", 32'(pattin), 32'd0);
    repeat (12) tick();
    check("ab_still_idle", 32'(busy), 32'd0);
    check("ab_no_done", 32'(done_cnt), 32'(dc));

    // Reset mid-run.
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mr_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_pattin", 32'(pattin), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_results", {22'd0, resp, fail_cnt, first_fail, ffv, pass}, 32'd0);
    check("mr_aborted", 32'(aborted), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("mr_no_done", 32'(done_cnt), 32'(dc));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
